// File: rtl/isb_pkg.sv
// Shared types and defaults for the ISB prefetch stream buffer.
package isb_pkg;

  localparam int unsigned AW_DEF         = 16;
  localparam int unsigned CW_DEF         = 16;
  localparam int unsigned DEPTH_LOG2_DEF = 2;

  typedef enum logic [2:0] {
    ST_EMPTY    = 3'd0,
    ST_QUEUED   = 3'd1,
    ST_ISSUING  = 3'd2,
    ST_INFLIGHT = 3'd3,
    ST_FILLED   = 3'd4
  } entry_st_e;

endpackage

// File: rtl/isb_sat_ctr.sv
// Saturating up-counter used for the stream buffer statistics.
module isb_sat_ctr
  import isb_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/isb_stream_buf.sv
// Prefetch stream buffer: dedups ISB candidates, issues them one at a time,
// tracks fills and reports demand hits on buffered entries.
module isb_stream_buf
  import isb_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned CW         = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pf_v,
  input  logic [AW-1:0] pf_addr,
  input  logic          dem_v,
  input  logic [AW-1:0] dem_addr,
  output logic          mem_req_v,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_req_ready,
  input  logic          mem_resp_v,
  input  logic [AW-1:0] mem_resp_addr,
  output logic          hit_v,
  output logic          hit_ready,
  output logic [AW-1:0] hit_addr,
  output logic [CW-1:0] stat_issued,
  output logic [CW-1:0] stat_hits,
  output logic [CW-1:0] stat_drops
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  entry_st_e     st_q     [DEPTH];
  entry_st_e     st_n     [DEPTH];
  logic [AW-1:0] addr_q   [DEPTH];
  logic [AW-1:0] addr_n   [DEPTH];
  logic          cancel_q [DEPTH];
  logic          cancel_n [DEPTH];
  idx_t          wr_ptr_q, wr_ptr_n;
  idx_t          iss_idx_q, iss_idx_n;

  logic [DEPTH-1:0] dem_match, fill_match, pf_match;
  logic          handshake, pf_dup, ins, drop;
  logic          sel_found;
  idx_t          sel_idx, scan;
  logic          req_v_n, hit_v_n, hit_ready_n;
  logic [AW-1:0] req_addr_n, hit_addr_n;

  // Address matches, all against pre-edge state.
  always_comb begin
    dem_match  = '0;
    fill_match = '0;
    pf_match   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      dem_match[i]  = dem_v && (st_q[i] != ST_EMPTY) && (addr_q[i] == dem_addr);
      fill_match[i] = mem_resp_v && (st_q[i] == ST_INFLIGHT) && (addr_q[i] == mem_resp_addr);
      pf_match[i]   = (st_q[i] != ST_EMPTY) && (addr_q[i] == pf_addr);
    end
  end

  assign handshake = mem_req_v && mem_req_ready;
  assign pf_dup    = (|pf_match) || (dem_v && (dem_addr == pf_addr));
  assign ins       = pf_v && !pf_dup && (st_q[wr_ptr_q] != ST_ISSUING);
  assign drop      = pf_v && !ins;

  // Oldest QUEUED entry, skipping ones freed by demand or overwritten by insert.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan = wr_ptr_q + idx_t'(k);
      if (!sel_found && (st_q[scan] == ST_QUEUED) && !dem_match[scan] &&
          !(ins && (scan == wr_ptr_q))) begin
        sel_found = 1'b1;
        sel_idx   = scan;
      end
    end
  end

  always_comb begin
    hit_v_n     = |dem_match;
    hit_ready_n = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (dem_match[i] && (st_q[i] == ST_FILLED)) begin
        hit_ready_n = 1'b1;
      end
    end
    hit_addr_n = hit_v_n ? dem_addr : '0;
  end

  // Entry updates applied in priority order: demand, fill, issue, insert.
  always_comb begin
    st_n       = st_q;
    addr_n     = addr_q;
    cancel_n   = cancel_q;
    wr_ptr_n   = wr_ptr_q;
    iss_idx_n  = iss_idx_q;
    req_v_n    = mem_req_v;
    req_addr_n = mem_req_addr;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (dem_match[i]) begin
        if (st_q[i] == ST_ISSUING) begin
          cancel_n[i] = 1'b1;
        end else begin
          st_n[i] = ST_EMPTY;
        end
      end else if (fill_match[i]) begin
        st_n[i] = ST_FILLED;
      end
    end

    if (handshake) begin
      st_n[iss_idx_q] = cancel_n[iss_idx_q] ? ST_EMPTY : ST_INFLIGHT;
      req_v_n         = 1'b0;
      req_addr_n      = '0;
    end else if (!mem_req_v && sel_found) begin
      st_n[sel_idx] = ST_ISSUING;
      iss_idx_n     = sel_idx;
      req_v_n       = 1'b1;
      req_addr_n    = addr_q[sel_idx];
    end

    if (ins) begin
      st_n[wr_ptr_q]     = ST_QUEUED;
      addr_n[wr_ptr_q]   = pf_addr;
      cancel_n[wr_ptr_q] = 1'b0;
      wr_ptr_n           = wr_ptr_q + idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_q[i]     <= ST_EMPTY;
        addr_q[i]   <= '0;
        cancel_q[i] <= 1'b0;
      end
      wr_ptr_q     <= '0;
      iss_idx_q    <= '0;
      mem_req_v    <= 1'b0;
      mem_req_addr <= '0;
      hit_v        <= 1'b0;
      hit_ready    <= 1'b0;
      hit_addr     <= '0;
    end else begin
      st_q         <= st_n;
      addr_q       <= addr_n;
      cancel_q     <= cancel_n;
      wr_ptr_q     <= wr_ptr_n;
      iss_idx_q    <= iss_idx_n;
      mem_req_v    <= req_v_n;
      mem_req_addr <= req_addr_n;
      hit_v        <= hit_v_n;
      hit_ready    <= hit_ready_n;
      hit_addr     <= hit_addr_n;
    end
  end

  isb_sat_ctr #(.CW(CW)) u_ctr_issued (
    .clk(clk), .rst_n(rst_n), .en(handshake), .count(stat_issued)
  );

  isb_sat_ctr #(.CW(CW)) u_ctr_hits (
    .clk(clk), .rst_n(rst_n), .en(hit_v_n), .count(stat_hits)
  );

  isb_sat_ctr #(.CW(CW)) u_ctr_drops (
    .clk(clk), .rst_n(rst_n), .en(drop), .count(stat_drops)
  );

endmodule
